// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add MUL beside the EX-stage ALU; low WIDTH product bits, done pulse.
// Latency: start in cycle 0, WIDTH RUN cycles, done_o/result_o in cycle WIDTH+1.
// Backpressure: stall_o holds the pipeline from the start cycle through the last RUN cycle.
module alu_mul_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [2:0]  MUL_CODE = 3'b011
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_sum;
    logic             start;
    logic             last_iter;

    // rst_i gates start so stall_o drops the instant reset asserts, even with a MUL in EX
    assign start     = rst_i && (state_q == ST_IDLE) && valid_i &&
                       (ALUCtrl_i == MUL_CODE) && !flush_i;
    assign last_iter = (cnt_q == LAST_ITER);
    assign addend    = mplier_q[0] ? mcand_q : '0;
    assign acc_sum   = acc_q + addend;

    assign stall_o = start || (state_q == ST_RUN);
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            // EX still holds the retiring MUL here; never restart on it
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_o <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_q  <= data1_i;
                        mplier_q <= data2_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                ST_RUN: begin
                    // a flushed run leaves result_o at its previous value
                    if (!flush_i) begin
                        acc_q    <= acc_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        if (last_iter) begin
                            result_o <= acc_sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: vector table, random products, flush/reset/back-to-back sequences.
module tb_alu_mul_sequencer;

    localparam int W = 32;
    localparam logic [2:0] MUL = 3'b011;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic [2:0]   ALUCtrl_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic         flush_i;
    logic         stall_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] model_result;

    alu_mul_sequencer #(.WIDTH(W), .MUL_CODE(MUL)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ALUCtrl_i(ALUCtrl_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Issue one MUL at the next cycle and follow it to done_o; cycle 0 is the start cycle.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input bit release_after,
                          input string name);
        int done_cyc;
        int stall_cnt;
        int busy_cnt;
        logic [W-1:0] res;
        done_cyc  = -1;
        stall_cnt = 0;
        busy_cnt  = 0;
        res       = '0;
        @(posedge clk_i); #1;
        valid_i   = 1'b1;
        ALUCtrl_i = MUL;
        data1_i   = a;
        data2_i   = b;
        flush_i   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (stall_o) stall_cnt++;
            if (busy_o)  busy_cnt++;
            if (done_o) begin
                done_cyc = k;
                res      = result_o;
                break;
            end
        end
        chk({name, " done_cycle"}, 64'(done_cyc), 64'd33);
        chk({name, " stall_cycles"}, 64'(stall_cnt), 64'd33);
        chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        chk({name, " result"}, 64'(res), 64'(exp));
        model_result = exp;
        if (release_after) begin
            @(posedge clk_i); #1;
            valid_i   = 1'b0;
            ALUCtrl_i = 3'b000;
            @(negedge clk_i);
            chk({name, " idle_after_done"}, {61'd0, stall_o, busy_o, done_o}, 64'd0);
            chk({name, " result_held"}, 64'(result_o), 64'(model_result));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [63:0]  prod;
        bit           saw_done;

        tbl[0] = '{a: 32'd3,          b: 32'd5,          exp: 32'h0000_000F};
        tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 32'hFFFF_FFFE};
        tbl[2] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  exp: 32'h0000_0000};
        tbl[3] = '{a: 32'd6,          b: 32'd7,          exp: 32'd42};
        tbl[4] = '{a: 32'd0,          b: 32'd12345,      exp: 32'd0};
        tbl[5] = '{a: 32'h8000_0000,  b: 32'd1,          exp: 32'h8000_0000};
        tbl[6] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 32'h0000_0001};
        tbl[7] = '{a: 32'h1234_5678,  b: 32'h10,         exp: 32'h2345_6780};

        rst_i     = 1'b0;
        valid_i   = 1'b0;
        ALUCtrl_i = 3'b000;
        data1_i   = '0;
        data2_i   = '0;
        flush_i   = 1'b0;
        model_result = '0;

        repeat (2) @(negedge clk_i);
        chk("reset_outputs", {28'd0, stall_o, busy_o, done_o, 1'b0, result_o}, 64'd0);
        @(posedge clk_i); #3;
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_mul(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1, $sformatf("vec%0d", i));
        end

        // Non-MUL codes pass through: no stall, no state change.
        for (int c = 0; c < 8; c++) begin
            if (c != 3) begin
                @(posedge clk_i); #1;
                valid_i   = 1'b1;
                ALUCtrl_i = 3'(c);
                data1_i   = $urandom;
                data2_i   = $urandom;
                @(negedge clk_i);
                chk($sformatf("passthru_code%0d", c),
                    {29'd0, stall_o, busy_o, done_o, result_o}, {32'd0, model_result});
            end
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("passthru_no_busy_after", 64'(busy_o), 64'd0);

        // Flush in IDLE suppresses start.
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = MUL; data1_i = 32'd4; data2_i = 32'd4; flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_idle_stall", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_idle_busy", 64'(busy_o), 64'd0);

        // Flush mid-run: 7*9 aborted at cycle 10.
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = MUL; data1_i = 32'd7; data2_i = 32'd9;
        for (int k = 0; k < 10; k++) @(negedge clk_i);
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_run_busy_c10", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_run_idle_c11", {62'd0, stall_o, busy_o}, 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        chk("flush_run_no_done", 64'(saw_done), 64'd0);
        chk("flush_run_result_kept", 64'(result_o), 64'(model_result));

        // Randomized products against 64-bit arithmetic.
        for (int i = 0; i < 6; i++) begin
            ra   = $urandom;
            rb   = (i < 3) ? W'($urandom_range(0, 1000)) : W'($urandom);
            prod = 64'(ra) * 64'(rb);
            do_mul(ra, rb, prod[W-1:0], 1'b1, $sformatf("rand%0d", i));
        end

        // Asynchronous reset at cycle 15 of a run.
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = MUL; data1_i = 32'd11; data2_i = 32'd13;
        for (int k = 0; k < 16; k++) @(negedge clk_i);
        chk("pre_reset_busy", 64'(busy_o), 64'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("reset_midrun_outputs", {29'd0, stall_o, busy_o, done_o, result_o}, 64'd0);
        model_result = '0;
        valid_i = 1'b0;
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        do_mul(32'd6, 32'd7, 32'd42, 1'b1, "after_reset_6x7");

        // Back-to-back: second MUL presented the cycle after DONE.
        do_mul(32'd2, 32'd3, 32'd6, 1'b0, "b2b_first");
        do_mul(32'd4, 32'd5, 32'd20, 1'b1, "b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
